// File: rtl/textlcd_ctrl.sv
// HD44780-style 2x16 character LCD sequencer: power-on wait, init commands, then continuous
// refresh of both lines from a per-frame snapshot of eight 32-bit text words.
module textlcd_ctrl #(
  parameter int unsigned P_PWRON = 375000,
  parameter int unsigned P_SETUP = 2,
  parameter int unsigned P_PULSE = 12,
  parameter int unsigned P_HOLD  = 2,
  parameter int unsigned P_GAP   = 1000,
  parameter int unsigned P_CLR   = 41000,
  parameter int unsigned P_FRAME = 250000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] textdata_a,
  input  logic [31:0] textdata_b,
  input  logic [31:0] textdata_c,
  input  logic [31:0] textdata_d,
  input  logic [31:0] textdata_e,
  input  logic [31:0] textdata_f,
  input  logic [31:0] textdata_g,
  input  logic [31:0] textdata_h,
  output logic        lcd_e,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic [7:0]  lcd_data,
  output logic        init_done,
  output logic        frame_done,
  output logic        busy
);

  localparam int unsigned M1 = (P_PWRON > P_FRAME) ? P_PWRON : P_FRAME;
  localparam int unsigned M2 = (M1 > P_CLR) ? M1 : P_CLR;
  localparam int unsigned M3 = (M2 > P_GAP) ? M2 : P_GAP;
  localparam int unsigned M4 = (P_SETUP > P_PULSE) ? P_SETUP : P_PULSE;
  localparam int unsigned M5 = (M4 > P_HOLD) ? M4 : P_HOLD;
  localparam int unsigned CntMax = (M3 > M5) ? M3 : M5;
  localparam int unsigned CW = $clog2(CntMax + 1);

  localparam logic [CW-1:0] PwronLast = CW'(P_PWRON - 1);
  localparam logic [CW-1:0] SetupLast = CW'(P_SETUP - 1);
  localparam logic [CW-1:0] PulseLast = CW'(P_PULSE - 1);
  localparam logic [CW-1:0] HoldLast  = CW'(P_HOLD - 1);
  localparam logic [CW-1:0] GapLast   = CW'(P_GAP - 1);
  localparam logic [CW-1:0] ClrLast   = CW'(P_CLR - 1);
  localparam logic [CW-1:0] FrameLast = CW'(P_FRAME - 1);

  typedef enum logic [2:0] {
    StPwrWait, StInit, StL1Addr, StL1Data, StL2Addr, StL2Data, StFrameGap
  } state_e;

  typedef enum logic [1:0] {PhSetup, PhPulse, PhHold, PhWait} phase_e;

  state_e         state_q;
  phase_e         phase_q;
  logic [CW-1:0]  cnt_q;
  logic [2:0]     init_idx_q;
  logic [3:0]     char_idx_q;
  logic [127:0]   line1_q;
  logic [127:0]   line2_q;

  logic           phase_last;
  logic [3:0]     next_idx;
  logic [7:0]     l1_next;
  logic [7:0]     l2_next;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1: init_cmd = 8'h38;
      3'd2:       init_cmd = 8'h0C;
      3'd3:       init_cmd = 8'h01;
      default:    init_cmd = 8'h06;
    endcase
  endfunction

  // Character idx 0 is the leftmost byte, i.e. the top byte of the line.
  function automatic logic [7:0] char_of(input logic [127:0] line, input logic [3:0] idx);
    logic [127:0] sh;
    sh = line >> {4'd15 - idx, 3'b000};
    char_of = sh[7:0];
  endfunction

  assign lcd_rw = 1'b0;

  always_comb begin
    phase_last = 1'b0;
    unique case (phase_q)
      PhSetup: phase_last = (cnt_q == SetupLast);
      PhPulse: phase_last = (cnt_q == PulseLast);
      PhHold:  phase_last = (cnt_q == HoldLast);
      PhWait:  phase_last = (cnt_q == ((!lcd_rs && lcd_data == 8'h01) ? ClrLast : GapLast));
    endcase
    next_idx = char_idx_q + 4'd1;
    l1_next  = char_of(line1_q, next_idx);
    l2_next  = char_of(line2_q, next_idx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StPwrWait;
      phase_q    <= PhSetup;
      cnt_q      <= '0;
      init_idx_q <= '0;
      char_idx_q <= '0;
      line1_q    <= {16{8'h20}};
      line2_q    <= {16{8'h20}};
      lcd_e      <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_data   <= 8'h00;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state_q)
        StPwrWait: begin
          if (cnt_q == PwronLast) begin
            cnt_q      <= '0;
            state_q    <= StInit;
            init_idx_q <= '0;
            phase_q    <= PhSetup;
            busy       <= 1'b1;
            lcd_rs     <= 1'b0;
            lcd_data   <= init_cmd(3'd0);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StFrameGap: begin
          // Counter parks at its last value so en is re-checked every cycle once expired.
          if (cnt_q == FrameLast) begin
            if (en) begin
              state_q  <= StL1Addr;
              line1_q  <= {textdata_a, textdata_b, textdata_c, textdata_d};
              line2_q  <= {textdata_e, textdata_f, textdata_g, textdata_h};
              cnt_q    <= '0;
              phase_q  <= PhSetup;
              busy     <= 1'b1;
              lcd_rs   <= 1'b0;
              lcd_data <= 8'h80;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          if (!phase_last) begin
            cnt_q <= cnt_q + CW'(1);
          end else begin
            cnt_q <= '0;
            unique case (phase_q)
              PhSetup: begin
                phase_q <= PhPulse;
                lcd_e   <= 1'b1;
              end
              PhPulse: begin
                phase_q <= PhHold;
                lcd_e   <= 1'b0;
              end
              PhHold: phase_q <= PhWait;
              PhWait: begin
                phase_q <= PhSetup;
                case (state_q)
                  StInit: begin
                    if (init_idx_q == 3'd4) begin
                      state_q   <= StFrameGap;
                      init_done <= 1'b1;
                      busy      <= 1'b0;
                      cnt_q     <= FrameLast;
                    end else begin
                      init_idx_q <= init_idx_q + 3'd1;
                      lcd_data   <= init_cmd(init_idx_q + 3'd1);
                    end
                  end
                  StL1Addr: begin
                    state_q    <= StL1Data;
                    char_idx_q <= '0;
                    lcd_rs     <= 1'b1;
                    lcd_data   <= line1_q[127:120];
                  end
                  StL1Data: begin
                    char_idx_q <= next_idx;
                    if (char_idx_q == 4'd15) begin
                      state_q  <= StL2Addr;
                      lcd_rs   <= 1'b0;
                      lcd_data <= 8'hC0;
                    end else begin
                      lcd_data <= l1_next;
                    end
                  end
                  StL2Addr: begin
                    state_q    <= StL2Data;
                    char_idx_q <= '0;
                    lcd_rs     <= 1'b1;
                    lcd_data   <= line2_q[127:120];
                  end
                  StL2Data: begin
                    char_idx_q <= next_idx;
                    if (char_idx_q == 4'd15) begin
                      state_q    <= StFrameGap;
                      frame_done <= 1'b1;
                      busy       <= 1'b0;
                    end else begin
                      lcd_data <= l2_next;
                    end
                  end
                  default: ;
                endcase
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: doc/textlcd_ctrl.md
Name: textlcd_ctrl

Overview:
Sequences a character-LCD module (HD44780-compatible, 8-bit bus, 2x16) from the eight 32-bit text words produced by the game/clock text generator.
- After reset: runs the power-on wait and init command sequence.
- Then refreshes continuously: line 1 from words a..d, line 2 from words e..h.
- Sits between the text generator and the board LCD pins. It is the only block that drives the LCD bus.

Parameters:
- P_PWRON, 375000: cycles to wait after reset before the first command (15 ms at 25 MHz).
- P_SETUP, 2: cycles RS/data are stable with E low before the E pulse.
- P_PULSE, 12: cycles E is high.
- P_HOLD, 2: cycles E is low with RS/data held after the pulse.
- P_GAP, 1000: idle cycles after a normal command or data byte (40 us).
- P_CLR, 41000: idle cycles after the clear command 0x01, used instead of P_GAP.
- P_FRAME, 250000: idle cycles between refresh frames.

Ports:
- clk, input, 1: system clock, 25 MHz.
- reset, input, 1: synchronous, active-high reset.
- en, input, 1: refresh enable, sampled only at frame boundaries.
- textdata_a .. textdata_h, input, 32 each: 4 ASCII characters per word, bits [31:24] are leftmost.
- lcd_e, output, 1: LCD enable strobe.
- lcd_rs, output, 1: 0 = command, 1 = data.
- lcd_rw, output, 1: tied to 0 (write only).
- lcd_data, output, 8: LCD data bus.
- init_done, output, 1: high once the init sequence has completed.
- frame_done, output, 1: one-cycle pulse after the last character of line 2 has been written.
- busy, output, 1: high whenever a byte transfer is in progress.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-high, and takes priority over everything.
  - Reset values: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, init_done=0, frame_done=0, busy=0, state=PWR_WAIT, all counters 0, snapshot registers 0x20202020.
  - Reset mid-transfer aborts immediately. E drops low in the same cycle that reset is sampled. The full power-on sequence then restarts.
- Byte engine: phases SETUP(P_SETUP) -> PULSE(P_PULSE, lcd_e=1) -> HOLD(P_HOLD) -> WAIT(P_GAP, or P_CLR for 0x01).
  - lcd_rs and lcd_data are constant for the whole transfer.
  - A transfer occupies exactly P_SETUP+P_PULSE+P_HOLD+(P_GAP|P_CLR) cycles.
  - busy=1 for exactly those cycles.
  - The next byte's SETUP begins on the cycle after WAIT ends.
- Top FSM states and transitions:
  - PWR_WAIT: count P_PWRON cycles, then go to INIT.
  - INIT: commands 0x38, 0x38, 0x0C, 0x01, 0x06 in that order, rs=0. After the last WAIT: init_done<=1, go to FRAME_GAP with its counter preloaded to expire (the first frame starts immediately if en=1).
  - L1_ADDR: command 0x80.
  - L1_DATA: 16 data bytes, rs=1.
  - L2_ADDR: command 0xC0.
  - L2_DATA: 16 data bytes, rs=1.
  - FRAME_GAP: count P_FRAME cycles, then go to L1_ADDR if en=1. If en=0, stay in FRAME_GAP and re-check every cycle.
- Snapshot: on entry to L1_ADDR, all eight text words are registered.
  - Both lines of a frame come from this snapshot. Input changes mid-frame are ignored (no tearing).
  - Character order: a[31:24], a[23:16], a[15:8], a[7:0], b[31:24] ... d[7:0] on line 1; e..h likewise on line 2.
- Character index: 4-bit counter, wraps 15 -> 0 on the line switch.
- frame_done pulses on the cycle after the WAIT phase of the 32nd character ends, coincident with entry to FRAME_GAP.
- en: deasserting en mid-frame does not stop the frame; the frame always completes. en has no effect during PWR_WAIT or INIT.
- init_done stays 1 until reset.

Test Plan:
(All scenarios use P_PWRON=10, P_SETUP=1, P_PULSE=2, P_HOLD=1, P_GAP=4, P_CLR=8, P_FRAME=5.)
- Reset, en=1 -> all outputs 0. The first lcd_e rise is 11 cycles after reset release. E pulses carry 0x38, 0x38, 0x0C, 0x01, 0x06 with rs=0. The 0x01 slot is 12 cycles; the others are 8. init_done rises after the 0x06 slot.
- textdata_a=0x47616D65 ("Game"), others 0x20202020 -> after the 0x80 command, E pulses carry 0x47, 0x61, 0x6D, 0x65, then 12 x 0x20, with rs=1. Then 0xC0 with rs=0, then 16 x 0x20. frame_done is high for exactly 1 cycle.
- Change textdata_e to 0x54696D65 while line 1 is being written -> line 2 of the current frame shows the old value. The next frame shows 0x54, 0x69, 0x6D, 0x65.
- en=0 during init and for 3 frame-gap periods -> no frame starts and lcd_e stays 0. Raise en -> 0x80 is issued on the next cycle.
- Assert reset during the PULSE phase of a data byte -> lcd_e=0 on the next edge, init_done=0, and the 10-cycle power-on wait plus the init sequence repeat.
- Across all scenarios: lcd_rs and lcd_data never change while lcd_e=1; lcd_rw is always 0; busy matches the transfer windows exactly.
